// File: rtl/fp_cmp_pkg.sv
// Shared types and opcode constants for the single-precision compare path.
// Used by the compare arbiter and its sub-blocks.
package fp_cmp_pkg;

  localparam logic [2:0] CMP_LE = 3'b000;
  localparam logic [2:0] CMP_LT = 3'b001;
  localparam logic [2:0] CMP_EQ = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  func3;
  } cmp_op_t;

  function automatic logic func3_legal(input logic [2:0] f);
    return (f == CMP_LE) || (f == CMP_LT) || (f == CMP_EQ);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, with wrap.
// Shared by the FPU resource arbiters.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant
);

  logic [W-1:0] idx;
  logic         found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = W'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sp_compare.sv
// Single-precision FEQ/FLT/FLE with IEEE invalid flag.
// Results are only driven while start is high; done mirrors start.
module SP_Compare
  import fp_cmp_pkg::*;
(
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  func3,
  output logic        flag_cmp,
  output logic        flag_invalid,
  output logic        done
);

  logic nan_a, nan_b, snan_a, snan_b, any_nan;
  logic both_zero, eq, lt;
  logic raw_cmp, raw_inv;

  assign nan_a   = (&a[30:23]) && (|a[22:0]);
  assign nan_b   = (&b[30:23]) && (|b[22:0]);
  assign snan_a  = nan_a && !a[22];
  assign snan_b  = nan_b && !b[22];
  assign any_nan = nan_a || nan_b;

  assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
  assign eq        = both_zero || (a == b);

  // Sign-magnitude ordering; negative magnitudes order in reverse.
  always_comb begin
    lt = 1'b0;
    if (both_zero)
      lt = 1'b0;
    else if (a[31] != b[31])
      lt = a[31];
    else if (a[31])
      lt = a[30:0] > b[30:0];
    else
      lt = a[30:0] < b[30:0];
  end

  always_comb begin
    raw_cmp = 1'b0;
    raw_inv = 1'b0;
    unique case (func3)
      CMP_EQ: begin
        raw_cmp = !any_nan && eq;
        raw_inv = snan_a || snan_b;
      end
      CMP_LT: begin
        raw_cmp = !any_nan && lt;
        raw_inv = any_nan;
      end
      CMP_LE: begin
        raw_cmp = !any_nan && (lt || eq);
        raw_inv = any_nan;
      end
      default: begin
        raw_cmp = 1'b0;
        raw_inv = 1'b0;
      end
    endcase
  end

  assign flag_cmp     = start && raw_cmp;
  assign flag_invalid = start && raw_inv;
  assign done         = start;

endmodule

// File: rtl/sp_cmp_arbiter.sv
// Round-robin sequencer sharing one SP_Compare between NUM_REQ requesters,
// with a held response and a sticky NV accrued-exception bit.
module sp_cmp_arbiter
  import fp_cmp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*3-1:0] req_func3,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output logic                 resp_cmp,
  output logic                 resp_invalid,
  output logic                 resp_illegal,
  input  logic                 resp_ready,
  output logic                 nv_sticky,
  input  logic                 nv_clear,
  output logic                 busy
);

  state_e          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] op_id;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] ptr_nxt;
  logic [NUM_REQ-1:0] grant;
  cmp_op_t         op;
  cmp_op_t         win_op;
  logic            accept;
  logic            legal;
  logic            cmp_start;
  logic            flag_cmp;
  logic            flag_invalid;
  logic            cmp_done;

  rr_arbiter #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    win_id = '0;
    win_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_id       = ID_W'(i);
        win_op.a     = req_a[i*32 +: 32];
        win_op.b     = req_b[i*32 +: 32];
        win_op.func3 = req_func3[i*3 +: 3];
      end
    end
  end

  // Grant is suppressed while reset is held so nothing looks accepted.
  assign req_ready = (rst_n && state == IDLE) ? grant : '0;
  assign accept    = |req_ready;
  assign ptr_nxt   = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
  assign legal     = func3_legal(op.func3);
  assign cmp_start = (state == EXEC) && legal;
  assign busy      = (state != IDLE);

  SP_Compare u_cmp (
    .start        (cmp_start),
    .a            (op.a),
    .b            (op.b),
    .func3        (op.func3),
    .flag_cmp     (flag_cmp),
    .flag_invalid (flag_invalid),
    .done         (cmp_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      op     <= '0;
      op_id  <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (accept) begin
            state  <= EXEC;
            op     <= win_op;
            op_id  <= win_id;
            rr_ptr <= ptr_nxt;
          end
        end
        (state == EXEC): state <= RESP;
        (state == RESP): begin
          if (resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_cmp     <= 1'b0;
      resp_invalid <= 1'b0;
      resp_illegal <= 1'b0;
    end else if (state == EXEC) begin
      resp_valid   <= 1'b1;
      resp_id      <= op_id;
      resp_cmp     <= flag_cmp;
      resp_invalid <= flag_invalid;
      resp_illegal <= !legal;
    end else if (state == RESP && resp_ready) begin
      resp_valid   <= 1'b0;
    end
  end

  // A set in the same cycle as a clear must win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      nv_sticky <= 1'b0;
    else if (state == EXEC && flag_invalid)
      nv_sticky <= 1'b1;
    else if (nv_clear)
      nv_sticky <= 1'b0;
  end

  a_done: assert property (@(posedge clk) disable iff (!rst_n)
    cmp_done == cmp_start);

  a_no_illegal_start: assert property (@(posedge clk) disable iff (!rst_n)
    (state == EXEC && !legal) |-> !cmp_start);

endmodule

// File: tb/tb_sp_cmp_arbiter.sv
// Bench for sp_cmp_arbiter: directed cases plus random traffic
// against a transaction-level model.
module tb_sp_cmp_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N*3-1:0] req_func3 = '0;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic           resp_cmp;
  logic           resp_invalid;
  logic           resp_illegal;
  logic           resp_ready = 1'b1;
  logic           nv_sticky;
  logic           nv_clear = 1'b0;
  logic           busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sp_cmp_arbiter #(.NUM_REQ(N)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_func3    (req_func3),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_cmp     (resp_cmp),
    .resp_invalid (resp_invalid),
    .resp_illegal (resp_illegal),
    .resp_ready   (resp_ready),
    .nv_sticky    (nv_sticky),
    .nv_clear     (nv_clear),
    .busy         (busy)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Numeric value of a non-NaN float; infinities map to +/-1e300.
  function automatic real fval(logic [31:0] x);
    real m;
    int  e;
    e = int'(x[30:23]);
    if (e == 255)
      m = 1.0e300;
    else if (e == 0)
      m = real'(x[22:0]) * (2.0 ** -149.0);
    else
      m = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
    return x[31] ? -m : m;
  endfunction

  // Returns {illegal, cmp, invalid}.
  function automatic logic [2:0] ref_cmp(logic [31:0] a, logic [31:0] b,
                                         logic [2:0] f);
    logic na, nb, sa, sb, anyn;
    real  ra, rb;
    na   = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb   = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    sa   = na && !a[22];
    sb   = nb && !b[22];
    anyn = na || nb;
    if (f > 3'd2) return 3'b100;
    ra = fval(a);
    rb = fval(b);
    if (f == 3'd2) return {1'b0, !anyn && (ra == rb), sa || sb};
    if (f == 3'd1) return {1'b0, !anyn && (ra < rb), anyn};
    return {1'b0, !anyn && (ra <= rb), anyn};
  endfunction

  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Model: phase 0 idle, 1 computing, 2 response held.
  int         m_phase = 0;
  int         m_ptr = 0;
  int         m_id = 0;
  int         m_w;
  logic [2:0] m_res = 3'b000;
  logic       m_nv = 1'b0;

  always_comb m_w = pick(req_valid, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_ptr   <= 0;
      m_id    <= 0;
      m_res   <= 3'b000;
      m_nv    <= 1'b0;
    end else begin
      if (m_phase == 0 && m_w >= 0) begin
        m_id    <= m_w;
        m_res   <= ref_cmp(req_a[m_w*32 +: 32], req_b[m_w*32 +: 32],
                           req_func3[m_w*3 +: 3]);
        m_ptr   <= (m_w + 1) % N;
        m_phase <= 1;
      end else if (m_phase == 1) begin
        m_phase <= 2;
      end else if (m_phase == 2 && resp_ready) begin
        m_phase <= 0;
      end
      m_nv <= (m_phase == 1 && m_res[0]) ? 1'b1 : (nv_clear ? 1'b0 : m_nv);
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] er;
    er = (!rst_n || m_phase != 0 || m_w < 0) ? '0 : N'(1) << m_w;
    chk("m_req_ready", 32'(req_ready), 32'(er));
    chk("m_resp_valid", 32'(resp_valid), 32'(rst_n && m_phase == 2));
    chk("m_busy", 32'(busy), 32'(rst_n && m_phase != 0));
    chk("m_nv_sticky", 32'(nv_sticky), 32'(m_nv));
    chk("m_start", 32'(u_dut.cmp_start),
        32'(rst_n && m_phase == 1 && !m_res[2]));
    if (rst_n && m_phase == 2) begin
      chk("m_resp_id", 32'(resp_id), 32'(m_id));
      chk("m_resp_cmp", 32'(resp_cmp), 32'(m_res[1]));
      chk("m_resp_inv", 32'(resp_invalid), 32'(m_res[0]));
      chk("m_resp_ill", 32'(resp_illegal), 32'(m_res[2]));
    end
  end

  task automatic set_op(int r, logic [31:0] a, logic [31:0] b,
                        logic [2:0] f);
    req_a[r*32 +: 32]  = a;
    req_b[r*32 +: 32]  = b;
    req_func3[r*3 +: 3] = f;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  // Starts and ends one cycle after a rising edge.
  task automatic do_op(int r, logic [31:0] a, logic [31:0] b, logic [2:0] f,
                       logic ec, logic ei, logic el, logic clr);
    int n, c0;
    set_op(r, a, b, f);
    req_valid[r] = 1'b1;
    n = 0;
    @(negedge clk);
    while (req_ready == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant", 32'(req_ready), 32'(1) << r);
    c0 = cyc;
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    nv_clear = clr;
    @(negedge clk);
    chk("exec_start", 32'(u_dut.cmp_start), 32'(!el));
    @(posedge clk);
    #1;
    nv_clear = 1'b0;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(cyc - c0), 2);
    chk("resp_id", 32'(resp_id), 32'(r));
    chk("resp_cmp", 32'(resp_cmp), 32'(ec));
    chk("resp_inv", 32'(resp_invalid), 32'(ei));
    chk("resp_ill", 32'(resp_illegal), 32'(el));
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pool [12] = '{
    32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
    32'h40000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
    32'h7F800001, 32'hFFC00000, 32'h00000001, 32'h7F7FFFFF
  };

  function automatic logic [31:0] rnd_val();
    if ($urandom_range(0, 2) == 0) return $urandom;
    return pool[$urandom_range(0, 11)];
  endfunction

  function automatic logic [2:0] rnd_f();
    if ($urandom_range(0, 5) == 0) return 3'($urandom_range(3, 7));
    return 3'($urandom_range(0, 2));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gid[$];
    int gcy[$];
    int n, maxw;
    int wt[N];
    logic [N-1:0] g;
    logic [4:0] snap;

    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_nv", 32'(nv_sticky), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fairness with every requester valid.
    for (int i = 0; i < N; i++) set_op(i, rnd_val(), rnd_val(), rnd_f());
    req_valid = '1;
    n = 0;
    while (gid.size() < 5 && n < 60) begin
      @(negedge clk);
      n++;
      if (req_ready != 0) begin
        gid.push_back($clog2(req_ready));
        gcy.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("fair_count", 32'(gid.size()), 5);
    for (int i = 0; i < gid.size(); i++) begin
      chk("fair_order", 32'(gid[i]), 32'(i % N));
      if (i > 0) chk("fair_gap", 32'(gcy[i] - gcy[i-1]), 3);
    end
    wait_idle();

    do_op(2, 32'h3F800000, 32'h40000000, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(0, 32'h7F800001, 32'h3F800000, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("nv_after_snan", 32'(nv_sticky), 1);
    @(posedge clk);
    #1;
    do_op(1, 32'h7FC00000, 32'h7FC00000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(3, 32'h7FC00000, 32'h3F800000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op(2, 32'h00000000, 32'h80000000, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(0, 32'h3F800000, 32'h40000000, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op(1, 32'hBF800000, 32'h3F800000, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(3, 32'h40000000, 32'h40000000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Sticky bit: clear alone, then clear racing a set.
    nv_clear = 1'b1;
    @(posedge clk);
    #1;
    nv_clear = 1'b0;
    @(negedge clk);
    chk("nv_clear_alone", 32'(nv_sticky), 0);
    @(posedge clk);
    #1;
    do_op(1, 32'h7F800001, 32'h00000000, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("nv_set_wins", 32'(nv_sticky), 1);
    @(posedge clk);
    #1;
    nv_clear = 1'b1;
    @(posedge clk);
    #1;
    nv_clear = 1'b0;
    @(negedge clk);
    chk("nv_clear_next", 32'(nv_sticky), 0);
    @(posedge clk);
    #1;

    // Response stall with another requester waiting.
    resp_ready = 1'b0;
    set_op(3, 32'h40400000, 32'h40000000, 3'b001);
    req_valid[3] = 1'b1;
    n = 0;
    @(negedge clk);
    while (req_ready == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    set_op(0, 32'h3F800000, 32'h3F800000, 3'b010);
    req_valid[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_id", 32'(resp_id), 3);
    chk("stall_cmp", 32'(resp_cmp), 0);
    snap = {resp_valid, resp_id, resp_cmp, resp_invalid};
    repeat (10) begin
      @(negedge clk);
      chk("stall_hold", 32'({resp_valid, resp_id, resp_cmp, resp_invalid}),
          32'(snap));
      chk("stall_ready", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (req_ready == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_next_grant", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    wait_idle();

    // Random traffic.
    maxw = 0;
    for (int i = 0; i < N; i++) wt[i] = 0;
    repeat (800) begin
      @(negedge clk);
      g = req_ready;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !g[i]) wt[i]++;
        if (wt[i] > maxw) maxw = wt[i];
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          req_valid[i] = 1'b0;
          wt[i] = 0;
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          set_op(i, rnd_val(), rnd_val(), rnd_f());
          req_valid[i] = 1'b1;
        end
      end
      resp_ready = ($urandom_range(0, 2) != 0);
      nv_clear = ($urandom_range(0, 9) == 0);
    end
    chk("no_starvation", 32'(maxw <= 150), 1);
    req_valid = '0;
    resp_ready = 1'b1;
    nv_clear = 1'b0;
    wait_idle();

    // Reset during EXEC abandons the operation.
    set_op(3, 32'h3F800000, 32'h3F800000, 3'b010);
    req_valid[3] = 1'b1;
    n = 0;
    @(negedge clk);
    while (req_ready == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    set_op(1, 32'h3F800000, 32'h40000000, 3'b001);
    req_valid[1] = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(req_ready), 0);
    chk("rst_mid_valid", 32'(resp_valid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_id", 32'(resp_id), 0);
    chk("rst_mid_flags",
        32'({resp_cmp, resp_invalid, resp_illegal, nv_sticky}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("post_rst_id", 32'(resp_id), 1);
    chk("post_rst_cmp", 32'(resp_cmp), 1);
    @(posedge clk);
    #1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_cmp_arbiter.md
# sp_cmp_arbiter

Round-robin arbiter and sequencer that shares one single-precision compare unit (SP_Compare: FEQ/FLT/FLE) between NUM_REQ requesters, for example the scalar FPU issue port and vector-lane helpers. It accepts one request at a time and registers the operands into the compare unit. It captures the compare and invalid result and holds a response until the winning requester takes it. It also keeps a sticky NV (invalid) accrued-exception bit for the fcsr.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- ID_W, default $clog2(NUM_REQ): width of the requester index.

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept, combinational.
- req_a  in  NUM_REQ*32  operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*32  operand B, packed the same way.
- req_func3  in  NUM_REQ*3  compare opcode: 010 FEQ, 001 FLT, 000 FLE.
- resp_valid  out  1  response available.
- resp_id  out  ID_W  index of the requester that owns the response.
- resp_cmp  out  1  compare result.
- resp_invalid  out  1  IEEE invalid flag for this operation.
- resp_illegal  out  1  func3 was not one of 000/001/010.
- resp_ready  in  1  response consumer accepts.
- nv_sticky  out  1  accrued NV bit.
- nv_clear  in  1  synchronous clear of nv_sticky.
- busy  out  1  FSM not in IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - Grant the first i with req_valid[i], searching from rr_ptr upward with wrap.
  - Assert req_ready[i] only for the winner. All other bits of req_ready are 0.
  - On the grant, latch the winner's a, b, func3 and id, set rr_ptr = (id+1) mod NUM_REQ, and go to EXEC.
  - With no req_valid, stay in IDLE.
- EXEC:
  - Drive the latched operands into SP_Compare with start=1 for exactly this cycle.
  - On the clock edge, capture flag_cmp and flag_invalid into the response registers and go to RESP.
  - Illegal func3: do not assert start. Capture resp_cmp=0, resp_invalid=0, resp_illegal=1.
- RESP:
  - Hold resp_valid=1 with stable resp_id, resp_cmp, resp_invalid and resp_illegal.
  - On resp_valid&resp_ready, return to IDLE.
  - Back-to-back operation is not supported: req_ready is 0 outside IDLE.
- nv_sticky:
  - Set on the EXEC edge when the captured flag_invalid is 1.
  - nv_clear in the same cycle as a set: set wins and nv_sticky stays 1.
  - nv_clear alone: nv_sticky goes to 0 next edge.
- Compare semantics come from SP_Compare:
  - Any NaN operand gives resp_cmp 0.
  - FEQ raises invalid only for sNaN.
  - FLT/FLE raise invalid for any NaN.
  - +0 and -0 compare equal.
- Requesters must hold req_valid and their operands stable until granted.
- The arbiter never drops a pending request.
- With all requesters continuously valid, each one is granted once every NUM_REQ operations.

## Timing
- Reset (asynchronous assert, synchronous deassert upstream):
  - state=IDLE, rr_ptr=0.
  - resp_valid, resp_cmp, resp_invalid, resp_illegal, nv_sticky and busy all 0.
  - resp_id=0, req_ready=0.
  - Reset mid-operation abandons the in-flight request with no response.
- Latency:
  - Accept edge at cycle 0; EXEC during cycle 1; resp_valid high from cycle 2.
  - Minimum issue interval is 3 cycles (accept, EXEC, RESP with resp_ready=1, then IDLE).
- req_ready depends combinationally on req_valid and state only, never on resp_ready.
- resp_ready held low stalls in RESP indefinitely; outputs do not change during the stall.
- busy = (state != IDLE), registered-state derived.

## Structure
- Shared package fp_cmp_pkg:
  - func3 constants CMP_LE=3'b000, CMP_LT=3'b001, CMP_EQ=3'b010.
  - State enum {IDLE, EXEC, RESP}.
  - Legal-func3 check function.
- Sub-module rr_arbiter (parameter N): inputs req and ptr, output one-hot grant. It is combinational and reusable by other FPU resource arbiters.
- One SP_Compare instance, with done unused except by assertions (done==start).

## Test plan
- Single request: requester 2 sends FLT a=0x3F800000 (1.0), b=0x40000000 (2.0) -> req_ready=0100 at cycle 0, resp_valid at cycle 2 with resp_id=2, resp_cmp=1, resp_invalid=0.
- NaN flags:
  - FEQ with a=0x7F800001 (sNaN) -> cmp=0, invalid=1, nv_sticky=1.
  - FEQ with a=0x7FC00000 (qNaN) -> cmp=0, invalid=0.
  - FLE with the same qNaN -> invalid=1.
- Zero and illegal opcode:
  - FEQ a=0x00000000, b=0x80000000 -> cmp=1.
  - func3=3'b111 -> resp_illegal=1, cmp=0, invalid=0, and start never asserted.
- Fairness: all 4 req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0, with one grant every 3 cycles.
- Stall and sticky flag:
  - resp_ready=0 for 10 cycles -> outputs stable, req_ready=0.
  - nv_clear coincident with an invalid capture -> nv_sticky stays 1.
  - nv_clear alone on the next cycle -> nv_sticky goes to 0.
- Reset: assert rst_n=0 during EXEC -> all outputs 0 immediately. After release, a pending request from requester 1 is granted first, because rr_ptr=0 and requester 1 is the lowest valid index searching up from 0.
